// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
// Contents: RISC-V load/store funct3 codes, error codes on err_o, FSM state type.
package riscv_mem_pkg;

  // Access size/sign (funct3 of LOAD/STORE)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // err_o encoding
  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } mem_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit.
// Ports:
//   mem_rd_i, mem_wr_i, funct3_i, addr_lo_i : live access from EX/MEM (decode + store lanes)
//   store_data_i                            : rs2 value
//   ld_funct3_i, ld_addr_lo_i               : captured load size/offset used for extraction
//   rdata_i                                 : raw bus read word
//   be_o, wdata_o                           : byte enables and lane-replicated store data
//   ld_data_o                               : aligned, sign/zero-extended load result
//   misalign_o, illegal_o                   : access decode faults
module lsu_align
  import riscv_mem_pkg::*;
(
  input  logic        mem_rd_i,
  input  logic        mem_wr_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_addr_lo_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ld_data_o,
  output logic        misalign_o,
  output logic        illegal_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store lanes: size comes from funct3[1:0]; only legal codes ever reach the bus.
  always_comb begin
    be_o    = 4'b1111;
    wdata_o = store_data_i;
    unique case (funct3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        be_o    = 4'b0011 << addr_lo_i;
        wdata_o = {2{store_data_i[15:0]}};
      end
      default: begin
        be_o    = 4'b1111;
        wdata_o = store_data_i;
      end
    endcase
  end

  // Load extraction
  always_comb begin
    unique case (ld_addr_lo_i)
      2'd0:    ld_byte = rdata_i[7:0];
      2'd1:    ld_byte = rdata_i[15:8];
      2'd2:    ld_byte = rdata_i[23:16];
      default: ld_byte = rdata_i[31:24];
    endcase
    ld_half = ld_addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    unique case (ld_funct3_i)
      F3_B:    ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data_o = {24'h0, ld_byte};
      F3_H:    ld_data_o = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data_o = {16'h0, ld_half};
      default: ld_data_o = rdata_i;
    endcase
  end

  // Fault decode; illegal takes priority over misalignment in the FSM.
  always_comb begin
    illegal_o = 1'b0;
    if (mem_rd_i && mem_wr_i) begin
      illegal_o = 1'b1;
    end else if (mem_rd_i) begin
      illegal_o = (funct3_i == 3'b011) || (funct3_i == 3'b110) || (funct3_i == 3'b111);
    end else if (mem_wr_i) begin
      illegal_o = !((funct3_i == F3_B) || (funct3_i == F3_H) || (funct3_i == F3_W));
    end

    misalign_o = ((funct3_i[1:0] == 2'b01) && addr_lo_i[0]) ||
                 ((funct3_i[1:0] == 2'b10) && (addr_lo_i != 2'b00));
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: runs one req/gnt/rvalid data-bus transaction per
// memory instruction, stalls the pipeline until it completes, and presents the
// aligned load result and error code for exactly one DONE cycle.
// Ports:
//   clk, reset                      : clock, asynchronous active-high reset
//   valid_i, mem_rd_i, mem_wr_i     : live instruction and its load/store kind
//   funct3_i, addr_i, store_data_i  : access size/sign, effective address, rs2
//   dmem_*_o / dmem_*_i             : data-memory bus (registered request side)
//   mem_rd_data_o                   : last captured load result (held)
//   stall_o                         : freeze upstream stages while an access is open
//   err_o                           : error code, meaningful in the DONE cycle only
module mem_access_unit
  import riscv_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_i,
  input  logic        mem_rd_i,
  input  logic        mem_wr_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] store_data_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic [31:0] mem_rd_data_o,
  output logic        stall_o,
  output logic [1:0]  err_o
);

  localparam logic [15:0] TimeoutLim = 16'(TIMEOUT_CYCLES);

  mem_state_t  state_q;
  logic [15:0] cnt_q;
  logic [15:0] cnt_inc;
  logic [2:0]  ld_funct3_q;
  logic [1:0]  ld_addr_lo_q;

  logic        op;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_ld_data;
  logic        al_misalign;
  logic        al_illegal;

  assign op      = valid_i & (mem_rd_i | mem_wr_i);
  assign stall_o = op & (state_q != DONE);
  assign cnt_inc = cnt_q + 16'd1;

  lsu_align u_align (
    .mem_rd_i     (mem_rd_i),
    .mem_wr_i     (mem_wr_i),
    .funct3_i     (funct3_i),
    .addr_lo_i    (addr_i[1:0]),
    .store_data_i (store_data_i),
    .ld_funct3_i  (ld_funct3_q),
    .ld_addr_lo_i (ld_addr_lo_q),
    .rdata_i      (dmem_rdata_i),
    .be_o         (al_be),
    .wdata_o      (al_wdata),
    .ld_data_o    (al_ld_data),
    .misalign_o   (al_misalign),
    .illegal_o    (al_illegal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      dmem_req_o    <= 1'b0;
      dmem_we_o     <= 1'b0;
      dmem_addr_o   <= '0;
      dmem_be_o     <= '0;
      dmem_wdata_o  <= '0;
      mem_rd_data_o <= '0;
      err_o         <= ERR_NONE;
      ld_funct3_q   <= '0;
      ld_addr_lo_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (op) begin
            if (al_illegal) begin
              err_o   <= ERR_ILLEGAL;
              state_q <= DONE;
            end else if (al_misalign) begin
              err_o   <= ERR_MISALIGN;
              state_q <= DONE;
            end else begin
              dmem_req_o   <= 1'b1;
              dmem_we_o    <= mem_wr_i;
              dmem_addr_o  <= {addr_i[31:2], 2'b00};
              dmem_be_o    <= al_be;
              dmem_wdata_o <= al_wdata;
              ld_funct3_q  <= funct3_i;
              ld_addr_lo_q <= addr_i[1:0];
              cnt_q        <= '0;
              state_q      <= REQ;
            end
          end
        end

        REQ: begin
          // A grant in the expiry cycle still wins; WAIT then times out on >=.
          if (dmem_gnt_i) begin
            dmem_req_o <= 1'b0;
            cnt_q      <= cnt_inc;
            state_q    <= dmem_we_o ? DONE : WAIT;
          end else if (cnt_inc >= TimeoutLim) begin
            dmem_req_o <= 1'b0;
            err_o      <= ERR_TIMEOUT;
            state_q    <= DONE;
          end else begin
            cnt_q <= cnt_inc;
          end
        end

        WAIT: begin
          if (dmem_rvalid_i) begin
            mem_rd_data_o <= al_ld_data;
            state_q       <= DONE;
          end else if (cnt_inc >= TimeoutLim) begin
            err_o   <= ERR_TIMEOUT;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_inc;
          end
        end

        DONE: begin
          err_o   <= ERR_NONE;
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  import riscv_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid, mem_rd, mem_wr;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;

  logic        req0, we0, stall0;
  logic [31:0] addr0, wdata0, rd0;
  logic [3:0]  be0;
  logic [1:0]  err0;

  logic        req1, we1, stall1;
  logic [31:0] addr1, wdata1, rd1;
  logic [3:0]  be1;
  logic [1:0]  err1;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_rd;

  always #5 clk = ~clk;

  mem_access_unit u_dut (
    .clk (clk), .reset (reset), .valid_i (valid), .mem_rd_i (mem_rd), .mem_wr_i (mem_wr),
    .funct3_i (funct3), .addr_i (addr), .store_data_i (store_data),
    .dmem_req_o (req0), .dmem_we_o (we0), .dmem_addr_o (addr0), .dmem_be_o (be0),
    .dmem_wdata_o (wdata0), .dmem_gnt_i (dmem_gnt), .dmem_rvalid_i (dmem_rvalid),
    .dmem_rdata_i (dmem_rdata), .mem_rd_data_o (rd0), .stall_o (stall0), .err_o (err0)
  );

  // Short-timeout copy sharing all inputs; only examined in the timeout scenario.
  mem_access_unit #(.TIMEOUT_CYCLES (4)) u_dut_tmo (
    .clk (clk), .reset (reset), .valid_i (valid), .mem_rd_i (mem_rd), .mem_wr_i (mem_wr),
    .funct3_i (funct3), .addr_i (addr), .store_data_i (store_data),
    .dmem_req_o (req1), .dmem_we_o (we1), .dmem_addr_o (addr1), .dmem_be_o (be1),
    .dmem_wdata_o (wdata1), .dmem_gnt_i (dmem_gnt), .dmem_rvalid_i (dmem_rvalid),
    .dmem_rdata_i (dmem_rdata), .mem_rd_data_o (rd1), .stall_o (stall1), .err_o (err1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---- reference model ----
  function automatic logic [1:0] m_err(logic rd, logic wr, logic [2:0] f3, logic [31:0] a);
    int sz;
    if (rd && wr) return 2'd3;
    if (rd && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 2'd3;
    if (wr && f3 > 3'd2) return 2'd3;
    sz = 1 << f3[1:0];
    if (a % sz != 0) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [3:0] m_be(logic [2:0] f3, logic [31:0] a);
    int lane;
    lane = a % 4;
    if (f3 == 3'd0) return 4'(1 << lane);
    if (f3 == 3'd1) return 4'(3 << lane);
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(logic [2:0] f3, logic [31:0] sd);
    if (f3 == 3'd0) return {4{sd[7:0]}};
    if (f3 == 3'd1) return {2{sd[15:0]}};
    return sd;
  endfunction

  function automatic logic [31:0] m_load(logic [2:0] f3, logic [31:0] a, logic [31:0] rdat);
    logic [31:0] b, h;
    b = rdat >> (8 * (a % 4));
    h = rdat >> (16 * ((a % 4) / 2));
    case (f3)
      3'd0:    return {{24{b[7]}}, b[7:0]};
      3'd4:    return {24'h0, b[7:0]};
      3'd1:    return {{16{h[15]}}, h[15:0]};
      3'd5:    return {16'h0, h[15:0]};
      default: return rdat;
    endcase
  endfunction

  // Runs one access on u_dut, starting and ending at a negedge with the unit idle.
  // gd = gnt-less REQ cycles before grant; rd_dly = empty WAIT cycles before rvalid.
  task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] sd,
                           input logic [31:0] rdat, input int gd, input int rd_dly);
    logic [1:0] e;
    int  stalls, reqs, wcyc, exp_stalls;
    bit  granted, rv_done, done, is_load;
    e = m_err(rd, wr, f3, a);
    is_load = rd && !wr;
    stalls = 0; reqs = 0; wcyc = 0; granted = 0; rv_done = 0; done = 0;
    valid = 1'b1; mem_rd = rd; mem_wr = wr; funct3 = f3; addr = a; store_data = sd;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    #1;
    if (stall0) stalls++;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      if (!stall0) begin
        done = 1;
      end else begin
        stalls++;
        dmem_rvalid = 1'b0;
        dmem_rdata  = $urandom;
        if (granted && is_load && !rv_done) begin
          if (wcyc == rd_dly) begin
            dmem_rvalid = 1'b1;
            dmem_rdata  = rdat;
            rv_done     = 1;
          end else begin
            wcyc++;
          end
        end
        dmem_gnt = 1'b0;
        if (req0) begin
          chk("req_addr", addr0, {a[31:2], 2'b00});
          chk("req_we", 32'(we0), 32'(wr));
          if (wr) begin
            chk("req_be", 32'(be0), 32'(m_be(f3, a)));
            chk("req_wdata", wdata0, m_wdata(f3, sd));
          end
          if (reqs == gd) begin
            dmem_gnt = 1'b1;
            granted  = 1;
          end
          reqs++;
        end
      end
    end
    if (!done) chk("access_bound", 32'd0, 32'd1);
    if (e == 2'd0 && is_load) exp_rd = m_load(f3, a, rdat);
    exp_stalls = (e != 2'd0) ? 1 : 1 + (gd + 1) + (is_load ? rd_dly + 1 : 0);
    chk("done_err", 32'(err0), 32'(e));
    chk("done_rd_data", rd0, exp_rd);
    chk("stall_cycles", 32'(stalls), 32'(exp_stalls));
    chk("req_cycles", 32'(reqs), (e != 2'd0) ? 32'd0 : 32'(gd + 1));
    valid = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    @(negedge clk);
    chk("idle_err", 32'(err0), 32'd0);
  endtask

  initial begin
    logic        r_rd, r_wr;
    logic [2:0]  r_f3;
    logic [31:0] r_a;
    int          k, reqs;
    bit          done;

    reset = 1'b1; valid = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; funct3 = 3'd0;
    addr = '0; store_data = '0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    exp_rd = '0;
    #1;
    chk("rst_req", 32'(req0), 32'd0);
    chk("rst_addr", addr0, 32'd0);
    chk("rst_be", 32'(be0), 32'd0);
    chk("rst_wdata", wdata0, 32'd0);
    chk("rst_rd_data", rd0, 32'd0);
    chk("rst_err", 32'(err0), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Directed cases
    do_access(1, 0, F3_W,  32'h100, 32'h0, 32'hDEADBEEF, 0, 0);
    do_access(1, 0, F3_B,  32'h103, 32'h0, 32'h80FFFF7F, 0, 0);
    do_access(1, 0, F3_BU, 32'h103, 32'h0, 32'h80FFFF7F, 1, 2);
    do_access(1, 0, F3_HU, 32'h102, 32'h0, 32'h80FFFF7F, 0, 1);
    do_access(0, 1, F3_H,  32'h202, 32'h1234ABCD, 32'h0, 3, 0);
    do_access(0, 1, F3_B,  32'h201, 32'h123456A5, 32'h0, 0, 0);
    do_access(1, 0, F3_W,  32'h101, 32'h0, 32'h0, 0, 0);
    do_access(1, 0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 0);
    do_access(1, 1, F3_W,  32'h100, 32'h0, 32'h0, 0, 0);

    // Randomized accesses
    for (int i = 0; i < 60; i++) begin
      k    = $urandom_range(0, 9);
      r_rd = (k < 5);
      r_wr = (k >= 4);
      r_f3 = 3'($urandom_range(0, 7));
      if (r_wr && !r_rd && $urandom_range(0, 3) != 0) r_f3 = 3'($urandom_range(0, 2));
      r_a = $urandom;
      if ($urandom_range(0, 1) == 1) r_a[1:0] = 2'b00;
      do_access(r_rd, r_wr, r_f3, r_a, $urandom, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Reset while waiting for read data
    valid = 1'b1; mem_rd = 1'b1; mem_wr = 1'b0; funct3 = F3_W; addr = 32'h300;
    @(negedge clk);
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    chk("wait_stall", 32'(stall0), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_req", 32'(req0), 32'd0);
    chk("midrst_addr", addr0, 32'd0);
    chk("midrst_be", 32'(be0), 32'd0);
    chk("midrst_rd_data", rd0, 32'd0);
    chk("midrst_err", 32'(err0), 32'd0);
    valid = 1'b0;
    @(negedge clk);
    reset  = 1'b0;
    exp_rd = '0;
    do_access(1, 0, F3_W, 32'h40, 32'h0, 32'hCAFEF00D, 0, 0);
    chk("tmo_unit_rd_data", rd1, 32'hCAFEF00D);

    // Timeout on the short-timeout unit: grant never arrives
    valid = 1'b1; mem_rd = 1'b1; mem_wr = 1'b0; funct3 = F3_W; addr = 32'h80;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    reqs = 0; done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (!stall1) done = 1;
      else if (req1) reqs++;
    end
    chk("tmo_bound", 32'(done), 32'd1);
    chk("tmo_req_cycles", 32'(reqs), 32'd4);
    chk("tmo_req_low", 32'(req1), 32'd0);
    chk("tmo_err", 32'(err1), 32'(ERR_TIMEOUT));
    chk("tmo_rd_hold", rd1, 32'hCAFEF00D);
    valid = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h11111111;
    repeat (2) @(negedge clk);
    dmem_rvalid = 1'b0;
    chk("late_rvalid_rd", rd1, 32'hCAFEF00D);
    chk("late_rvalid_err", 32'(err1), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store unit between the EX/MEM and MEM/WB pipeline registers.
- Takes the address and store data from EX/MEM and runs a req/gnt/rvalid transaction on the data-memory bus.
- Aligns and extends load data, and stalls the pipeline until the access completes.
- Its load data, stall and error outputs feed the MEM/WB register and the hazard unit.

Parameters:
- TIMEOUT_CYCLES, 255, cycles spent in REQ+WAIT before the access is aborted with a bus error (1..65535).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- valid_i  in  1  MEM stage holds a live instruction.
- mem_rd_i  in  1  instruction is a load.
- mem_wr_i  in  1  instruction is a store.
- funct3_i  in  3  access size/sign, RISC-V encoding.
- addr_i  in  32  effective address (ALU result).
- store_data_i  in  32  rs2 value.
- dmem_req_o  out  1  bus request.
- dmem_we_o  out  1  1 = write.
- dmem_addr_o  out  32  word-aligned address ({addr_i[31:2],2'b00}).
- dmem_be_o  out  4  byte enables.
- dmem_wdata_o  out  32  lane-replicated store data.
- dmem_gnt_i  in  1  bus accepted request.
- dmem_rvalid_i  in  1  read data valid.
- dmem_rdata_i  in  32  read data.
- mem_rd_data_o  out  32  aligned, extended load result to MEM/WB.
- stall_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; MEM/WB captures a bubble.
- err_o  out  2  00 none, 01 misaligned, 10 bus timeout, 11 illegal access; valid in the DONE cycle only.

Behaviour:
- Reset: state IDLE, dmem_req_o=0, dmem_we_o=0, dmem_addr_o=0, dmem_be_o=0, dmem_wdata_o=0, mem_rd_data_o=0, err_o=0, timeout counter=0. Reset mid-transaction abandons the access.
- op = valid_i & (mem_rd_i | mem_wr_i).
- stall_o = op & (state != DONE). Combinational; 0 in DONE.
- FSM states IDLE, REQ, WAIT, DONE:
  - IDLE, no op: stay.
  - IDLE, illegal or misaligned op: go to DONE with err set, no bus access.
    - Illegal: mem_rd_i&mem_wr_i both set; load funct3 in {011,110,111}; store funct3 not in {000,001,010}.
    - Misaligned: half with addr[0]=1; word with addr[1:0]!=0.
  - IDLE, legal op: register bus outputs and go to REQ; dmem_req_o=1 from the next cycle.
  - REQ: hold req/addr/be/wdata/we stable until dmem_gnt_i. On gnt, drop req; store -> DONE, load -> WAIT.
  - WAIT: on dmem_rvalid_i, capture the extended data into mem_rd_data_o and go to DONE. rvalid outside WAIT is ignored.
  - DONE: exactly one cycle; outputs presented, stall_o=0, pipeline advances at the clock edge, then go to IDLE.
- Timeout: counter clears on entering REQ and increments each REQ/WAIT cycle. When it reaches TIMEOUT_CYCLES: drop req, go to DONE with err=10, and leave mem_rd_data_o unchanged.
- err_o is registered and returns to 00 in IDLE.
- mem_rd_data_o holds its value until the next load capture.
- Store lanes:
  - SB: wdata = byte replicated x4, be = 0001<<addr[1:0].
  - SH: wdata = half replicated x2, be = 0011<<addr[1:0].
  - SW: be = 1111.
- Load extract: LB/LBU select byte addr[1:0]; LH/LHU select half addr[1]; sign-extend for LB/LH, zero-extend for LBU/LHU.
- Best case: load = 3 stall cycles + DONE (gnt in first REQ cycle, rvalid the next); store = 2 stall cycles + DONE.

Decomposition:
- Shared package riscv_mem_pkg:
  - funct3 constants F3_B/H/W/BU/HU.
  - ERR_NONE/MISALIGN/TIMEOUT/ILLEGAL.
  - mem_state_t enum {IDLE, REQ, WAIT, DONE}.
- One combinational sub-module, lsu_align, owns the be/wdata generation, load extraction, and misalign/illegal decode.
- mem_access_unit keeps the FSM, timeout counter and output registers.

Test Plan:
- LW addr 0x100, gnt in first REQ cycle, rvalid next with 0xDEADBEEF -> stall_o high 3 cycles, DONE with mem_rd_data_o=0xDEADBEEF, err 00.
- LB addr 0x103, rdata 0x80FF_FF7F -> 0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x102 -> 0x000080FF.
- SH addr 0x202, data 0x1234ABCD -> dmem_be_o=1100, dmem_wdata_o=0xABCDABCD, dmem_we_o=1, held through 3 gnt-less cycles, DONE after gnt.
- LW addr 0x101 -> no dmem_req_o, DONE next cycle, err_o=01; funct3=011 load -> err_o=11.
- TIMEOUT_CYCLES=4, gnt never -> req drops after 4 REQ cycles, err_o=10, mem_rd_data_o unchanged, late rvalid ignored.
- reset asserted while in WAIT -> req low, state IDLE, all outputs 0 immediately; a new LW after release completes normally.
